layer_mapper_stream: RTL and testbench
======================================

# layer_mapper_stream

Streaming, parametrised layer mapper for the downlink PDSCH chain. It accepts modulation symbols one per cycle from one or two codewords under a valid/ready handshake. It distributes them across up to `MAX_LAYERS` spatial layers, with the per-codeword layer split set by the configured layer count. It emits one layer vector (one symbol per active layer) per output beat to the precoder. It replaces the fixed 2-codeword/8-layer mapper with configurable layer count, backpressure, block framing and error reporting.

## Interface
- `SYM_W`, 32, bits per modulation symbol (I/Q packed)
- `MAX_LAYERS`, 8, maximum layers; must be even, ≥2
- `LW`, `$clog2(MAX_LAYERS+1)`, width of layer-count fields
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_layers` in LW: layer count L for the next block; legal range 1..MAX_LAYERS
- `in_valid` in 1: input symbol valid
- `in_ready` out 1: block accepts the symbol this cycle
- `in_sym` in SYM_W: modulation symbol
- `in_cw` in 1: codeword tag (0/1) of `in_sym`
- `in_last` in 1: last symbol of the transport block
- `out_valid` out 1: layer vector valid
- `out_ready` in 1: downstream accepts the vector
- `out_data` out MAX_LAYERS*SYM_W: layer j at `[j*SYM_W +: SYM_W]`
- `out_mask` out MAX_LAYERS: bit j set if layer j is active (bits 0..L-1)
- `out_last` out 1: final vector of the block
- `out_err` out 1: vector was padded or carried a codeword-tag mismatch
- `busy` out 1: a block is in progress (FILL state)

## Operation
- Layer split:
  - L0 = L when L ≤ MAX_LAYERS/2, otherwise floor(L/2).
  - Codeword 0 feeds layers 0..L0-1; codeword 1 feeds layers L0..L-1.
  - For the default configuration this is the 38.211 table.
- Input order per row: symbol k (0..L-1) maps to layer k. The expected tag is 0 for k<L0 and 1 otherwise. A mismatch sets the row's error bit; the symbol is still stored.
- State machine:
  - IDLE → FILL on the first accepted symbol. L and L0 are latched from `cfg_layers` on that handshake.
  - In FILL, the k counter increments per accepted symbol.
  - At k=L-1, or on `in_last`, the row is complete and k returns to 0.
  - On a completed row carrying `in_last`, the state returns to IDLE.
- Illegal `cfg_layers` (0 or >MAX_LAYERS) in IDLE: `in_ready`=0 and no symbol is accepted. The value is only sampled in IDLE.
- Early `in_last` (k<L-1): layers k+1..L-1 are zero-padded, and the row goes out with `out_err`=1 and `out_last`=1.
- `in_last` at k=L-1: normal final row, `out_err` reflects tag checks only.
- Buffering: one fill row register plus one output register (two-deep).
  - A completed row moves to the output register when that register is empty or being consumed in the same cycle.
  - Otherwise the row holds and `in_ready` deasserts until the transfer occurs.
- Inactive layer slices of `out_data` are always zero.

## Timing
- Reset values: `in_ready`=0 during reset, 1 from the first cycle after release (if cfg legal). `out_valid`, `out_data`, `out_mask`, `out_last`, `out_err`, `busy` = 0. State is IDLE and k=0.
- Latency: the row-completing symbol is accepted at edge t; `out_valid`=1 after edge t+1.
- Throughput: one symbol per cycle sustained while `out_ready`=1. There are no bubbles between rows or between blocks.
- `out_*` are held stable while `out_valid`=1 and `out_ready`=0.
- Row completion and output consumption in the same cycle: the new row loads the output register with no gap and no loss.
- `rst_n` asserted mid-row: partial data is discarded, all outputs clear immediately (asynchronous), and the block restarts in IDLE.
- `in_ready` is registered. It does not depend combinationally on `out_ready`.

## Test plan
- L=8, symbols 0x00..0x0F (tags 0,0,0,0,1,1,1,1 per row), `in_last` on 0x0F, `out_ready`=1:
  - Two vectors, each 1 cycle after its 8th symbol.
  - Row0 layers 0..7 = 0x00..0x07, `out_mask`=0xFF.
  - Row1 layers 0..7 = 0x08..0x0F, `out_last`=1, `out_err`=0.
- L=3, symbols 0xA1,0xA2,0xA3 all tag 0, `in_last` on 0xA3:
  - `out_mask`=0x07, layers 0..2 = A1..A3, layers 3..7 = 0, `out_last`=1.
- L=8, `out_ready`=0 for 20 cycles while streaming 24 symbols:
  - `in_ready` drops after the 16th accepted symbol.
  - After release, rows 0/1/2 emerge in order with no loss or duplication.
- L=4, `in_last` on the 2nd symbol (0x11,0x22):
  - Layers = 0x11,0x22,0,0, `out_mask`=0x0F, `out_err`=1, `out_last`=1.
  - Block returns to IDLE and re-samples `cfg_layers`.
- Tag checks:
  - L=6, tag 1 on k=1: that row has `out_err`=1; the next clean row has `out_err`=0.
  - L0=3 check: tags 0,0,0,1,1,1 give no error.
- Illegal configuration and reset:
  - `cfg_layers`=0, then 9: `in_ready` stays 0 for 10 cycles with `in_valid`=1.
  - `rst_n` pulsed low at k=5 of an L=8 row: all outputs read 0 immediately; no partial vector is emitted afterwards.

Source files
------------

// File: rtl/layer_mapper_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_mapper_stream_if
//  Purpose  : Symbol-in / layer-vector-out bundle for layer_mapper_stream.
//             Carries the input symbol handshake (in_*) and the output
//             layer-vector handshake (out_*).
//  Ports    : slave  - mapper side (consumes in_*, produces out_*)
//             master - source/sink side (produces in_*, consumes out_*)
//  Revision : 1.0 - initial release
// ============================================================================
interface layer_mapper_stream_if #(
  parameter int SYM_W      = 32,
  parameter int MAX_LAYERS = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [SYM_W-1:0]              in_sym;
  logic                          in_cw;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_LAYERS*SYM_W-1:0]   out_data;
  logic [MAX_LAYERS-1:0]         out_mask;
  logic                          out_last;
  logic                          out_err;

  modport slave (
    input  in_valid, in_sym, in_cw, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last, out_err
  );

  modport master (
    output in_valid, in_sym, in_cw, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last, out_err
  );
endinterface
`default_nettype wire

// File: rtl/layer_mapper_stream.sv
`default_nettype none
// ============================================================================
//  Module   : layer_mapper_stream
//  Purpose  : Streaming PDSCH layer mapper. Collects one symbol per accepted
//             beat into a row of L layers (codeword 0 on layers 0..L0-1,
//             codeword 1 on layers L0..L-1) and emits one layer vector per
//             completed row. Early block end zero-pads the row and flags it.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             cfg_layers - layer count L, sampled on the first symbol of a block
//             busy       - a block is being filled
//             bus        - symbol input / layer-vector output handshakes
//  Revision : 1.0 - initial release
// ============================================================================
module layer_mapper_stream #(
  parameter int SYM_W      = 32,
  parameter int MAX_LAYERS = 8,
  parameter int LW         = $clog2(MAX_LAYERS + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [LW-1:0]     cfg_layers,
  output logic                   busy,
  layer_mapper_stream_if.slave   bus
);

  localparam int DW   = MAX_LAYERS * SYM_W;
  localparam int HALF = MAX_LAYERS / 2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LW-1:0]       r_L;
  logic [LW-1:0]       r_k;
  logic                r_in_ready;

  // Fill row (row under construction, or completed and waiting)
  logic [DW-1:0]         r_row;
  logic [MAX_LAYERS-1:0] r_row_mask;
  logic                  r_row_err;
  logic                  r_row_last;
  logic                  r_row_full;

  // Output register
  logic [DW-1:0]         r_out_data;
  logic [MAX_LAYERS-1:0] r_out_mask;
  logic                  r_out_err;
  logic                  r_out_last;
  logic                  r_out_valid;

  logic                  w_cfg_ok;
  logic [LW-1:0]         w_L;
  logic [LW-1:0]         w_L0;
  logic [MAX_LAYERS-1:0] w_mask;
  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_row_done;
  logic                  w_tag_bad;
  logic                  w_pad;
  logic                  w_xfer;
  logic                  w_row_full_nxt;
  logic                  w_out_valid_nxt;

  assign w_cfg_ok = (cfg_layers != '0) && (cfg_layers <= LW'(MAX_LAYERS));

  // In IDLE the row being started uses the live configuration; it is latched
  // on that same handshake and held for the rest of the block.
  assign w_L  = (r_state == S_IDLE) ? cfg_layers : r_L;
  assign w_L0 = (w_L <= LW'(HALF)) ? w_L : (w_L >> 1);

  for (genvar j = 0; j < MAX_LAYERS; j++) begin : g_mask
    assign w_mask[j] = (LW'(j) < w_L);
  end

  // Registered ready, additionally gated so no symbol slips in under an
  // illegal layer count while idle.
  assign w_in_ready = r_in_ready && ((r_state == S_FILL) || w_cfg_ok);
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_row_done = w_acc && ((r_k == w_L - LW'(1)) || bus.in_last);
  assign w_tag_bad  = (bus.in_cw != (r_k >= w_L0));
  assign w_pad      = bus.in_last && (r_k != w_L - LW'(1));

  assign w_xfer          = r_row_full && (!r_out_valid || bus.out_ready);
  assign w_row_full_nxt  = w_row_done || (r_row_full && !w_xfer);
  assign w_out_valid_nxt = w_xfer || (r_out_valid && !bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc && !(w_row_done && bus.in_last)) w_state_nxt = S_FILL;
      S_FILL: if (w_row_done && bus.in_last)             w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_L         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_row       <= '0;
      r_row_mask  <= '0;
      r_row_err   <= 1'b0;
      r_row_last  <= 1'b0;
      r_row_full  <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_err   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Stall only when both stages will be occupied next cycle; a pending
      // row with an empty output stage is guaranteed to move on the next edge,
      // which frees the fill row for the incoming k=0 symbol.
      r_in_ready <= !(w_row_full_nxt && w_out_valid_nxt);

      if (w_acc) begin
        if (r_state == S_IDLE) begin
          r_L <= cfg_layers;
        end
        if (r_k == '0) begin
          // New row: clear all slots so unwritten and inactive layers read 0.
          r_row      <= '0;
          r_row_mask <= w_mask;
          r_row_err  <= w_tag_bad | w_pad;
        end else begin
          r_row_err  <= r_row_err | w_tag_bad | w_pad;
        end
        r_row[r_k*SYM_W +: SYM_W] <= bus.in_sym;
        r_row_last <= bus.in_last;
        r_k        <= w_row_done ? '0 : r_k + LW'(1);
      end

      r_row_full  <= w_row_full_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_xfer) begin
        r_out_data <= r_row;
        r_out_mask <= r_row_mask;
        r_out_err  <= r_row_err;
        r_out_last <= r_row_last;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_mask  = r_out_mask;
  assign bus.out_last  = r_out_last;
  assign bus.out_err   = r_out_err;
  assign busy          = (r_state == S_FILL);

endmodule
`default_nettype wire

// File: tb/tb_layer_mapper_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_mapper_stream
//  Purpose  : Self-checking bench for layer_mapper_stream. Expected layer
//             vectors are built per block by chunking the symbol list into
//             rows of L and applying the codeword split and padding rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_mapper_stream;
  localparam int SYM_W = 32;
  localparam int ML    = 8;
  localparam int LW    = $clog2(ML + 1);
  localparam int DW    = ML * SYM_W;

  typedef struct {
    logic [DW-1:0] data;
    logic [ML-1:0] mask;
    logic          last;
    logic          err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [LW-1:0] cfg_layers = LW'(8);
  logic          busy;

  layer_mapper_stream_if #(.SYM_W(SYM_W), .MAX_LAYERS(ML)) bus ();

  layer_mapper_stream #(.SYM_W(SYM_W), .MAX_LAYERS(ML)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_layers (cfg_layers),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  vec_t             exp_q[$];
  int               n_vec = 0;
  int               n_bad = 0;
  logic [SYM_W-1:0] syms[64];
  logic             tags[64];
  bit               ordy_rnd = 1'b0;
  logic             ordy_fixed = 1'b1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: split the block into rows of L; codeword 0 owns the first L0
  // layers of each row; a short last row is zero-padded and flagged.
  task automatic push_block(input int L, input int n);
    int   L0, nrows, idx;
    vec_t v;
    L0    = (L <= ML / 2) ? L : L / 2;
    nrows = (n + L - 1) / L;
    for (int r = 0; r < nrows; r++) begin
      v.data = '0;
      v.err  = 1'b0;
      v.mask = ML'((1 << L) - 1);
      v.last = (r == nrows - 1);
      for (int k = 0; k < L; k++) begin
        idx = r * L + k;
        if (idx < n) begin
          v.data[k*SYM_W +: SYM_W] = syms[idx];
          if (tags[idx] != (k >= L0)) v.err = 1'b1;
        end else begin
          v.err = 1'b1;
        end
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic fill_clean(input int L, input int n, input logic [SYM_W-1:0] base);
    int L0;
    L0 = (L <= ML / 2) ? L : L / 2;
    for (int i = 0; i < n; i++) begin
      syms[i] = base + SYM_W'(i);
      tags[i] = ((i % L) >= L0);
    end
  endtask

  task automatic send(input logic [SYM_W-1:0] s, input logic cw, input logic last);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_sym   = s;
    bus.in_cw    = cw;
    bus.in_last  = last;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 500) begin
        chk("send_timeout", DW'(bus.in_ready), DW'(1));
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_block(input int L, input int n, input int gap_pct);
    cfg_layers = LW'(L);
    push_block(L, n);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(posedge clk); #1;
      end
      send(syms[i], tags[i], i == n - 1);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  // out_ready driver, applied mid-cycle so it never races the DUT edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = ordy_rnd ? ($urandom_range(0, 3) != 0) : ordy_fixed;
    end
  end

  // Output monitor: consumes vectors on handshake, checks hold stability.
  logic          hold = 1'b0;
  logic [DW-1:0] h_data;
  logic [ML+2:0] h_ctl;
  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_data", bus.out_data, h_data);
        chk("hold_ctl", DW'({bus.out_valid, bus.out_mask, bus.out_last, bus.out_err}), DW'(h_ctl));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vec", DW'(bus.out_valid), DW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("data", bus.out_data, e.data);
          chk("mask", DW'(bus.out_mask), DW'(e.mask));
          chk("last", DW'(bus.out_last), DW'(e.last));
          chk("err",  DW'(bus.out_err),  DW'(e.err));
        end
      end
      hold   = bus.out_valid && !bus.out_ready;
      h_data = bus.out_data;
      h_ctl  = {bus.out_valid, bus.out_mask, bus.out_last, bus.out_err};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt, idx;
    bus.in_valid = 1'b0;
    bus.in_sym   = '0;
    bus.in_cw    = 1'b0;
    bus.in_last  = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", DW'(bus.in_ready), DW'(0));
    chk("rst_outs", DW'({bus.out_valid, bus.out_mask, bus.out_last, bus.out_err, busy}), DW'(0));
    chk("rst_data", bus.out_data, DW'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", DW'(bus.in_ready), DW'(1));
    @(posedge clk); #1;

    // L=8, 16 symbols, back-to-back: exact output timing, no bubbles
    fill_clean(8, 16, 32'h0);
    cfg_layers = LW'(8);
    push_block(8, 16);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        bus.in_valid = 1'b1;
        bus.in_sym   = syms[i];
        bus.in_cw    = tags[i];
        bus.in_last  = (i == 15);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 16) chk("t1_in_ready", DW'(bus.in_ready), DW'(1));
      chk("t1_out_valid", DW'(bus.out_valid), DW'(i == 9 || i == 17));
      @(posedge clk); #1;
    end
    drain();

    // L=3 short block
    syms[0] = 32'hA1; syms[1] = 32'hA2; syms[2] = 32'hA3;
    tags[0] = 1'b0;   tags[1] = 1'b0;   tags[2] = 1'b0;
    drive_block(3, 3, 0);
    drain();

    // L=8 with output stalled: ready drops after 16 accepted symbols
    fill_clean(8, 24, 32'h100);
    cfg_layers = LW'(8);
    push_block(8, 24);
    ordy_fixed = 1'b0;
    @(posedge clk); #1;
    acc_cnt = 0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1;
      bus.in_sym   = syms[idx];
      bus.in_cw    = tags[idx];
      bus.in_last  = (idx == 23);
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cnt++;
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("t3_accepted", DW'(acc_cnt), DW'(16));
    chk("t3_in_ready", DW'(bus.in_ready), DW'(0));
    ordy_fixed = 1'b1;
    for (int i = idx; i < 24; i++) send(syms[i], tags[i], i == 23);
    drain();

    // L=4 early last on the 2nd symbol
    syms[0] = 32'h11; syms[1] = 32'h22;
    tags[0] = 1'b0;   tags[1] = 1'b0;
    drive_block(4, 2, 0);
    drain();
    chk("t4_busy", DW'(busy), DW'(0));

    // L=6 (L0=3): tag error on k=1 of row 0, row 1 clean
    fill_clean(6, 12, 32'h600);
    tags[1] = 1'b1;
    drive_block(6, 12, 0);
    drain();

    // Illegal configurations hold off input
    cfg_layers   = LW'(0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) cfg_layers = LW'(9);
      @(negedge clk);
      if (c % 5 == 0) chk("illegal_in_ready", DW'(bus.in_ready), DW'(0));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("illegal_busy", DW'(busy), DW'(0));

    // Randomized blocks with random backpressure and input gaps
    ordy_rnd = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int L, n;
      L = $urandom_range(1, ML);
      n = $urandom_range(1, 24);
      fill_clean(L, n, $urandom);
      for (int i = 0; i < n; i++) begin
        syms[i] = $urandom;
        if ($urandom_range(0, 9) == 0) tags[i] = ~tags[i];
      end
      drive_block(L, n, 20);
    end
    drain();
    ordy_rnd = 1'b0;
    ordy_fixed = 1'b1;

    // Reset mid-row at k=5 of an L=8 row
    cfg_layers = LW'(8);
    for (int i = 0; i < 5; i++) send(32'hBEEF0000 + SYM_W'(i), 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_sym   = 32'hBEEF0005;
    bus.in_cw    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", DW'({bus.in_ready, bus.out_valid, bus.out_mask, bus.out_last, bus.out_err, busy}), DW'(0));
    chk("mid_rst_data", bus.out_data, DW'(0));
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_partial", DW'(bus.out_valid), DW'(0));

    // Restart after reset
    fill_clean(2, 4, 32'h2000);
    drive_block(2, 4, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
